call_ret_stack: RTL and testbench

// - Return-address stack feeding the target input of the PC update mux for CALL/RET.
// - CALL in decode pushes PC+1; RET pops and presents the saved address as next-PC target.
// - Sits between the decode stage (push/pop strobes) and the PC update logic (target_out, valid).
// - Single-cycle, zero-latency read of top-of-stack; writes take effect at the clock edge.

---
 rtl/call_ret_stack.sv | 129 ++++++++++++
 tb/tb_call_ret_stack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/call_ret_stack.sv
// Return-address stack for CALL/RET: push PC+1 on CALL, pop the saved target on RET.
// Build option: define RAS_WRAP_EN so that a push while full overwrites the oldest entry.
module call_ret_stack #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] target_out,
  output logic              target_valid,
  output logic              empty,
  output logic              full,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned SP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_count;
  logic              r_unf;

  logic [SP_W-1:0]   w_top_idx;
  logic              w_empty;
  logic              w_full;

  // sp is the next free slot, so the top entry sits one below it (mod DEPTH)
  assign w_top_idx = r_sp - SP_W'(1);
  assign w_empty   = (r_count == CNT_W'(0));
  assign w_full    = (r_count == CNT_W'(DEPTH));

  assign target_out    = w_empty ? ADDR_W'(0) : r_mem[w_top_idx];
  assign target_valid  = !w_empty;
  assign empty         = w_empty;
  assign full          = w_full;
  assign underflow_err = r_unf;

`ifdef RAS_WRAP_EN
  assign overflow_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '{default: '0};
      r_sp    <= '0;
      r_count <= '0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      case ({push, pop})
        2'b10: begin
          // when full, sp already points at the oldest entry
          r_mem[r_sp] <= push_addr;
          r_sp        <= r_sp + SP_W'(1);
          if (!w_full) r_count <= r_count + CNT_W'(1);
        end
        2'b01: begin
          if (!w_empty) begin
            r_sp    <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_unf <= 1'b1;
          end
        end
        2'b11: begin
          if (!w_empty) begin
            r_mem[w_top_idx] <= push_addr;
          end else begin
            r_mem[r_sp] <= push_addr;
            r_sp        <= r_sp + SP_W'(1);
            r_count     <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic r_ovf;

  assign overflow_err = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '{default: '0};
      r_sp    <= '0;
      r_count <= '0;
      r_unf   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (!stall) begin
      case ({push, pop})
        2'b10: begin
          if (!w_full) begin
            r_mem[r_sp] <= push_addr;
            r_sp        <= r_sp + SP_W'(1);
            r_count     <= r_count + CNT_W'(1);
          end else begin
            r_ovf <= 1'b1;
          end
        end
        2'b01: begin
          if (!w_empty) begin
            r_sp    <= w_top_idx;
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_unf <= 1'b1;
          end
        end
        2'b11: begin
          // simultaneous CALL/RET replaces the top; on empty it degrades to a push
          if (!w_empty) begin
            r_mem[w_top_idx] <= push_addr;
          end else begin
            r_mem[r_sp] <= push_addr;
            r_sp        <= r_sp + SP_W'(1);
            r_count     <= r_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_call_ret_stack.sv
// Scoreboard bench for call_ret_stack: a queue-based stack model predicts outputs per edge.
module tb_call_ret_stack;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] top;
    logic              valid;
    logic              emp;
    logic              ful;
    logic              ovf;
    logic              unf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [ADDR_W-1:0] target_out;
  logic              target_valid, empty, full, overflow_err, underflow_err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] m_stk[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  exp_t              exp_q[$];

  call_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .push(push), .push_addr(push_addr), .pop(pop),
    .target_out(target_out), .target_valid(target_valid), .empty(empty), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour: back of the queue is the top of the stack
  task automatic model_edge(input logic r, s, pu, po, input logic [ADDR_W-1:0] a);
    exp_t e;
    if (r) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!s) begin
      if (pu && po && m_stk.size() > 0) begin
        m_stk[m_stk.size()-1] = a;
      end else if (pu) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(a);
        else begin
`ifdef RAS_WRAP_EN
          m_stk.delete(0);
          m_stk.push_back(a);
`else
          m_ovf = 1'b1;
`endif
        end
      end else if (po) begin
        if (m_stk.size() > 0) m_stk.delete(m_stk.size()-1);
        else m_unf = 1'b1;
      end
    end
    e.top   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    e.valid = m_stk.size() > 0;
    e.emp   = m_stk.size() == 0;
    e.ful   = m_stk.size() == DEPTH;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, s, pu, po, input logic [ADDR_W-1:0] a);
    @(negedge clk);
    rst = r; stall = s; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    model_edge(r, s, pu, po, a);
  endtask

  // Monitor: outputs settle after each edge; compare against the oldest prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("target_out",    int'(target_out),    int'(e.top));
      check("target_valid",  int'(target_valid),  int'(e.valid));
      check("empty",         int'(empty),         int'(e.emp));
      check("full",          int'(full),          int'(e.ful));
      check("overflow_err",  int'(overflow_err),  int'(e.ovf));
      check("underflow_err", int'(underflow_err), int'(e.unf));
    end
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // basic LIFO order
    step(0, 0, 1, 0, 5'h03);
    step(0, 0, 1, 0, 5'h07);
    step(0, 0, 1, 0, 5'h1F);
    repeat (3) step(0, 0, 0, 1, 0);
    // replace top
    step(0, 0, 1, 0, 5'h04);
    step(0, 0, 1, 0, 5'h09);
    step(0, 0, 1, 1, 5'h11);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    // push+pop on empty acts as push without underflow
    step(0, 0, 1, 1, 5'h0C);
    step(0, 0, 0, 1, 0);
    // overflow
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, ADDR_W'(i));
    step(0, 0, 1, 0, 5'h0A);
    step(0, 1, 0, 1, 0);
    repeat (8) step(0, 0, 0, 1, 0);
    // underflow and stall
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 5'h05);
    // reset mid-operation with a push pending
    step(0, 0, 1, 0, 5'h12);
    step(0, 0, 1, 0, 5'h13);
    step(0, 0, 1, 0, 5'h14);
    step(1, 0, 1, 0, 5'h15);
    step(0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(7) == 0),
           ($urandom_range(99) < 55), ($urandom_range(99) < 45),
           ADDR_W'($urandom));
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; stall = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
